uart_rx_fifo: RTL and testbench

- UART receiver (8N1) that sits directly downstream of the board `rxd` pin and upstream of the md5 command parser inside top_md5.
- Synchronises the asynchronous serial line and recovers bytes using a fractional phase-accumulator baud generator (100 MHz / 12 Mbaud = 8.333 clocks per bit).
- Buffers received bytes in a small FIFO and presents them on a valid/ready byte stream.

---
 rtl/uart_rx_fifo.sv | 151 +++++++++++++++
 tb/tb_uart_rx_fifo.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with a fractional phase-accumulator baud generator,
// feeding a small byte FIFO presented as a valid/ready stream.
`timescale 1ns/1ps
module uart_rx_fifo #(
   parameter int unsigned CLK_FREQUENCY = 100_000_000,
   parameter int unsigned BAUD          = 12_000_000,
   parameter int unsigned FIFO_DEPTH    = 4
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       rxd,
   output logic [7:0] m_data,
   output logic       m_valid,
   input  logic       m_ready,
   output logic       err_frame,
   output logic       err_overrun
);
   localparam int AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic       rx_m, rx_s, rx_prev;
   logic [1:0] sync_vld;
   logic       armed;
   logic       start_edge;

   // sync_vld tracks when rx_s holds a real line sample rather than the reset
   // value, so a line held low across reset release is never seen as a start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rx_m     <= 1'b1;
         rx_s     <= 1'b1;
         rx_prev  <= 1'b1;
         sync_vld <= '0;
         armed    <= 1'b0;
      end else begin
         rx_m     <= rxd;
         rx_s     <= rx_m;
         rx_prev  <= rx_s;
         sync_vld <= {sync_vld[0], 1'b1};
         armed    <= armed | (sync_vld[1] & rx_s);
      end
   end

   assign start_edge = armed & rx_prev & ~rx_s;

   state_t      state, state_n;
   logic [31:0] acc, acc_n;
   logic [32:0] sum;
   logic        tick;
   logic [2:0]  bit_idx, bit_idx_n;
   logic [7:0]  shreg, shreg_n;
   logic        push_pend, push_pend_n;
   logic        frame_q, frame_n;

   assign sum  = {1'b0, acc} + 33'(BAUD);
   assign tick = (state != IDLE) && (sum >= 33'(CLK_FREQUENCY));

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         acc       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         push_pend <= 1'b0;
         frame_q   <= 1'b0;
      end else begin
         state     <= state_n;
         acc       <= acc_n;
         bit_idx   <= bit_idx_n;
         shreg     <= shreg_n;
         push_pend <= push_pend_n;
         frame_q   <= frame_n;
      end
   end

   always_comb begin
      state_n     = state;
      acc_n       = acc;
      bit_idx_n   = bit_idx;
      shreg_n     = shreg;
      push_pend_n = 1'b0;
      frame_n     = 1'b0;
      if (state != IDLE)
         acc_n = tick ? 32'(sum - 33'(CLK_FREQUENCY)) : sum[31:0];
      case (state)
         IDLE: begin
            // Half-period preload puts the first tick mid start bit.
            if (start_edge) begin
               state_n = START;
               acc_n   = 32'(CLK_FREQUENCY / 2);
            end
         end
         START: begin
            if (tick) begin
               if (!rx_s) begin
                  state_n   = DATA;
                  bit_idx_n = '0;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         DATA: begin
            if (tick) begin
               shreg_n   = {rx_s, shreg[7:1]};
               bit_idx_n = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_n = STOP;
            end
         end
         STOP: begin
            if (tick) begin
               state_n     = IDLE;
               push_pend_n = rx_s;
               frame_n     = ~rx_s;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   logic [FIFO_DEPTH-1:0][7:0] mem;
   logic [AW:0]                wr_ptr, rd_ptr;
   logic                       full, empty, pop, push;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop   = m_valid & m_ready;
   // shreg is untouched until the next DATA tick, so it still holds the byte here.
   assign push  = push_pend & (~full | pop);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         mem    <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr[AW-1:0]] <= shreg;
            wr_ptr              <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign m_valid     = ~empty;
   assign m_data      = mem[rd_ptr[AW-1:0]];
   assign err_frame   = frame_q;
   assign err_overrun = push_pend & full & ~pop;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: serial frames driven at 12 Mbaud, expected
// bytes queued at send time and popped as beats leave the FIFO.
`timescale 1ns/1ps
module tb_uart_rx_fifo;
   localparam real BIT_NS = 1000.0 / 12.0;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       rxd = 1'b1;
   logic       m_ready = 1'b1;
   logic [7:0] m_data;
   logic       m_valid, err_frame, err_overrun;

   int         checks = 0;
   int         errors = 0;
   int         n_frame = 0;
   int         n_ovr = 0;
   logic [7:0] exp_q[$];
   logic [7:0] popped;

   always #5 clk = ~clk;

   uart_rx_fifo #(
      .CLK_FREQUENCY(100_000_000),
      .BAUD(12_000_000),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .reset_n(reset_n),
      .rxd(rxd),
      .m_data(m_data),
      .m_valid(m_valid),
      .m_ready(m_ready),
      .err_frame(err_frame),
      .err_overrun(err_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Scoreboard consumer and error-pulse counters.
   always @(negedge clk) begin
      if (reset_n) begin
         if (m_valid && m_ready) begin
            chk("beat_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               popped = exp_q.pop_front();
               chk("beat_data", 32'(m_data), 32'(popped));
            end
         end
         if (err_frame)   n_frame++;
         if (err_overrun) n_ovr++;
         if (err_frame || err_overrun)
            chk("err_exclusive", 32'(err_frame & err_overrun), 32'd0);
      end
   end

   task automatic send_byte(input logic [7:0] b, input logic stop_bit, input logic expect_it);
      if (expect_it) exp_q.push_back(b);
      rxd = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         #(BIT_NS);
      end
      rxd = stop_bit;
      #(BIT_NS);
      rxd = 1'b1;
   endtask

   task automatic wait_empty(input string tag, input int budget);
      int k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         @(posedge clk);
         k++;
      end
      chk(tag, 32'(exp_q.size()), 32'd0);
   endtask

   task automatic chk_quiet_outputs(input string tag);
      chk({tag, "_m_data"},  32'(m_data), 32'd0);
      chk({tag, "_m_valid"}, 32'(m_valid), 32'd0);
      chk({tag, "_err_frame"}, 32'(err_frame), 32'd0);
      chk({tag, "_err_overrun"}, 32'(err_overrun), 32'd0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1 chk_quiet_outputs("reset");
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (10) @(posedge clk);

      // Single byte
      send_byte(8'h55, 1'b1, 1'b1);
      wait_empty("drain_55", 60);
      chk("t1_frame_cnt", 32'(n_frame), 32'd0);
      chk("t1_ovr_cnt", 32'(n_ovr), 32'd0);

      // Back-to-back frames, no idle gap
      send_byte(8'hA5, 1'b1, 1'b1);
      send_byte(8'h3C, 1'b1, 1'b1);
      send_byte(8'h00, 1'b1, 1'b1);
      send_byte(8'hFF, 1'b1, 1'b1);
      wait_empty("drain_b2b", 60);

      // Short glitch must be rejected silently
      @(posedge clk); #1 rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1 rxd = 1'b1;
      repeat (60) @(posedge clk);
      chk("glitch_frame_cnt", 32'(n_frame), 32'd0);
      chk("glitch_valid", 32'(m_valid), 32'd0);

      // Framing error, then a clean byte
      send_byte(8'hFF, 1'b0, 1'b0);
      #(BIT_NS * 2);
      send_byte(8'h12, 1'b1, 1'b1);
      wait_empty("drain_12", 60);
      chk("ferr_frame_cnt", 32'(n_frame), 32'd1);
      chk("ferr_ovr_cnt", 32'(n_ovr), 32'd0);

      // Overrun with consumer stalled
      @(posedge clk); #1 m_ready = 1'b0;
      for (int i = 1; i <= 5; i++)
         send_byte(8'(i), 1'b1, i <= 4);
      repeat (20) @(posedge clk);
      chk("stall_valid", 32'(m_valid), 32'd1);
      chk("stall_head", 32'(m_data), 32'h01);
      chk("stall_ovr_cnt", 32'(n_ovr), 32'd1);
      chk("stall_pending", 32'(exp_q.size()), 32'd4);
      @(posedge clk); #1 m_ready = 1'b1;
      wait_empty("drain_ovr", 40);
      repeat (3) @(posedge clk);
      chk("ovr_empty_after", 32'(m_valid), 32'd0);

      // Reset in the middle of data bit 4 of 0x77
      rxd = 1'b0;
      #(BIT_NS);
      for (int i = 0; i < 4; i++) begin
         rxd = (8'h77 >> i) & 8'h01;
         #(BIT_NS);
      end
      rxd = 1'b1;
      #(BIT_NS / 2);
      reset_n = 1'b0;
      #1 chk_quiet_outputs("midreset");
      repeat (4) @(posedge clk);
      #1 chk_quiet_outputs("midreset_hold");
      @(posedge clk); #1 reset_n = 1'b1;
      repeat (20) @(posedge clk);

      // Line already low at reset release is not a start bit
      #1 reset_n = 1'b0;
      rxd = 1'b0;
      repeat (3) @(posedge clk);
      #1 reset_n = 1'b1;
      repeat (120) @(posedge clk);
      chk("lowrel_frame_cnt", 32'(n_frame), 32'd1);
      chk("lowrel_valid", 32'(m_valid), 32'd0);
      #1 rxd = 1'b1;
      repeat (20) @(posedge clk);

      send_byte(8'h9C, 1'b1, 1'b1);
      wait_empty("drain_9c", 60);
      chk("final_frame_cnt", 32'(n_frame), 32'd1);
      chk("final_ovr_cnt", 32'(n_ovr), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
